// File: rtl/ahb_slave_fifo.sv
// AHB slave front-end: region decode, two-cycle ERROR response,
// ordered request FIFO toward the APB side and read data return.
module ahb_slave_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_SEL = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int REGION_SHIFT = 26,
  parameter int DEPTH = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hwrite,
  input  logic              hready_in,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [NUM_SEL-1:0] req_sel,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_W + DATA_W + NUM_SEL;
  localparam logic [ADDR_W:0] SPAN =
    (ADDR_W+1)'(NUM_SEL) << REGION_SHIFT;
  localparam logic [ADDR_W:0] LIMIT =
    {1'b0, BASE_ADDR} + SPAN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_RREQ,
    S_RWAIT,
    S_RDONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e              state_q;
  state_e              acc_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_SEL-1:0]  sel_q;
  logic [DATA_W-1:0]   hrdata_q;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [PW-1:0]       wr_q;
  logic [PW-1:0]       rd_q;
  logic [CW-1:0]       cnt_q;

  logic                acc;
  logic                map_ok;
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   idx;
  logic [NUM_SEL-1:0]  sel;
  logic                full;
  logic                push;
  logic                pop;
  logic                push_write;
  logic [DATA_W-1:0]   push_wdata;
  logic                unused_htrans0;

  assign unused_htrans0 = htrans[0];

  // Region decode of the current address phase
  always_comb begin
    map_ok = (haddr >= BASE_ADDR) &&
             ({1'b0, haddr} < LIMIT);
    off = haddr - BASE_ADDR;
    idx = off >> REGION_SHIFT;
    sel = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (map_ok && idx == ADDR_W'(i)) sel[i] = 1'b1;
    end
  end

  assign full = (cnt_q == CW'(DEPTH));
  assign req_valid = (cnt_q != '0);

  assign hready_out = (state_q == S_IDLE) ||
                      (state_q == S_RDONE) ||
                      (state_q == S_ERR2) ||
                      (state_q == S_WDATA && !full);

  assign hresp = (state_q == S_ERR1 || state_q == S_ERR2)
               ? 2'b01 : 2'b00;
  assign hrdata = hrdata_q;

  assign acc = hready_in & htrans[1] & hready_out;

  // Data-phase state entered by a newly accepted transfer
  always_comb begin
    acc_state = S_IDLE;
    if (acc) begin
      if (!map_ok)     acc_state = S_ERR1;
      else if (hwrite) acc_state = S_WDATA;
      else             acc_state = S_RREQ;
    end
  end

  // Full FIFO blocks the push even if the head pops this cycle
  assign push = (state_q == S_WDATA || state_q == S_RREQ) && !full;
  assign pop  = req_valid & req_ready;
  assign push_write = (state_q == S_WDATA);
  assign push_wdata = push_write ? hwdata : '0;

  // Transfer FSM: address capture, data phase, read return
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sel_q    <= '0;
      hrdata_q <= '0;
    end else begin
      if (acc) begin
        addr_q <= haddr;
        sel_q  <= sel;
      end
      unique case (state_q)
        S_RREQ: begin
          if (!full) state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          if (rd_valid) begin
            hrdata_q <= rd_data;
            state_q  <= S_RDONE;
          end
        end
        S_ERR1: state_q <= S_ERR2;
        default: begin
          if (hready_out) state_q <= acc_state;
        end
      endcase
    end
  end

  // Request storage, no reset needed: reads are gated by req_valid
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_q[wr_q] <= {push_write, addr_q, push_wdata, sel_q};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign {req_write, req_addr, req_wdata, req_sel} =
    req_valid ? mem_q[rd_q] : '0;

endmodule

// File: tb/tb_ahb_slave_fifo.sv
// Self-checking bench for ahb_slave_fifo: directed
// timing checks followed by a randomized scoreboard run.
module tb_ahb_slave_fifo;

  localparam int NS = 3;
  localparam int SH = 26;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } req_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel;
  logic        rd_valid;
  logic [31:0] rd_data;

  int n_assert = 0;
  int n_fail = 0;

  req_t        exp_q[$];
  req_t        e;
  bit          cur_v, cur_w, cur_map;
  logic [31:0] cur_wd, rexp, rd_val;
  int          rd_cd, stall;
  bit          abort, drain;

  always #5 hclk = ~hclk;

  ahb_slave_fifo dut (
    .hclk(hclk),
    .hreset(hreset),
    .hwrite(hwrite),
    .hready_in(hready_in),
    .htrans(htrans),
    .haddr(haddr),
    .hwdata(hwdata),
    .hready_out(hready_out),
    .hresp(hresp),
    .hrdata(hrdata),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_sel(req_sel),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference decode: which 64 MB region, as a one-hot
  function automatic logic [2:0] region(input logic [31:0] a);
    longint unsigned span;
    longint unsigned top;
    span = 64'd1 << SH;
    top = 64'(BASE) + 64'(NS) * span;
    if (a < BASE || 64'(a) >= top) return 3'b000;
    return 3'(1 << ((64'(a) - 64'(BASE)) / span));
  endfunction

  function automatic logic [31:0] bp_a(input int i);
    return BASE + (32'(i % 3) << SH) + 32'(i * 16);
  endfunction

  function automatic logic [31:0] bp_d(input int i);
    return 32'hB0B0_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    logic [31:0] off;
    logic [31:0] rg;
    r = int'($urandom_range(0, 9));
    off = $urandom & 32'h03FF_FFFF;
    rg = 32'($urandom_range(0, NS - 1));
    if (r < 8) return BASE + (rg << SH) + off;
    if (r == 8) return BASE + (32'(NS) << SH) + off;
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_ph(input logic w, input logic [31:0] a);
    htrans = 2'b10;
    hwrite = w;
    haddr = a;
  endtask

  task automatic idle();
    htrans = 2'b00;
  endtask

  // Five back-to-back writes into a stalled consumer
  task automatic burst5(input string tag);
    req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) addr_ph(1'b1, bp_a(i));
      else idle();
      if (i > 0) begin
        hwdata = bp_d(i - 1);
        chk(tag, 64'(hready_out), 64'(i < 5));
      end
      cyc();
    end
  endtask

  initial begin
    hreset = 1'b1;
    hwrite = 1'b0;
    hready_in = 1'b1;
    htrans = 2'b00;
    haddr = '0;
    hwdata = '0;
    req_ready = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    rd_cd = 0;
    stall = 0;
    abort = 0;
    cur_v = 0;
    rexp = '0;

    // reset values
    repeat (2) cyc();
    chk("rst_hready", hready_out, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_write", req_write, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_req_sel", req_sel, 0);
    hreset = 1'b0;
    cyc();

    // decode, zero wait states, draining consumer
    req_ready = 1'b1;
    addr_ph(1'b1, 32'h8140_1C85);
    cyc();
    hwdata = 32'h1111_0001;
    addr_ph(1'b1, 32'h8440_1C85);
    chk("dec_hready_1", hready_out, 1);
    cyc();
    hwdata = 32'h2222_0002;
    addr_ph(1'b1, 32'h8840_1C85);
    chk("dec_hready_2", hready_out, 1);
    chk("dec_valid_1", req_valid, 1);
    chk("dec_addr_1", req_addr, 32'h8140_1C85);
    chk("dec_write_1", req_write, 1);
    chk("dec_sel_1", req_sel, 3'b001);
    chk("dec_wdata_1", req_wdata, 32'h1111_0001);
    cyc();
    hwdata = 32'h3333_0003;
    idle();
    chk("dec_hready_3", hready_out, 1);
    chk("dec_sel_2", req_sel, 3'b010);
    chk("dec_wdata_2", req_wdata, 32'h2222_0002);
    cyc();
    chk("dec_sel_3", req_sel, 3'b100);
    chk("dec_wdata_3", req_wdata, 32'h3333_0003);
    cyc();
    chk("dec_empty", req_valid, 0);

    // unmapped write
    addr_ph(1'b1, 32'h8C40_1C85);
    cyc();
    idle();
    hwdata = 32'h0BAD_0BAD;
    chk("err_hready_1", hready_out, 0);
    chk("err_hresp_1", hresp, 2'b01);
    chk("err_nopush_1", req_valid, 0);
    cyc();
    chk("err_hready_2", hready_out, 1);
    chk("err_hresp_2", hresp, 2'b01);
    cyc();
    chk("err_hresp_3", hresp, 2'b00);
    chk("err_nopush_2", req_valid, 0);

    // backpressure: fifth write waits for the first pop
    burst5("bp_hready");
    chk("bp_stall_hold", hready_out, 0);
    chk("bp_head0_addr", req_addr, bp_a(0));
    chk("bp_head0_wdata", req_wdata, bp_d(0));
    chk("bp_head0_sel", req_sel, region(bp_a(0)));
    req_ready = 1'b1;
    cyc();
    chk("bp_fifth_done", hready_out, 1);
    for (int i = 1; i < 5; i++) begin
      chk("bp_order_addr", req_addr, bp_a(i));
      chk("bp_order_wdata", req_wdata, bp_d(i));
      chk("bp_order_sel", req_sel, region(bp_a(i)));
      cyc();
    end
    chk("bp_empty", req_valid, 0);

    // asynchronous reset in the middle of a write stall
    burst5("rst_fill_hready");
    hreset = 1'b1;
    #1;
    chk("rst_async_hready", hready_out, 1);
    chk("rst_async_hresp", hresp, 0);
    chk("rst_async_valid", req_valid, 0);
    chk("rst_async_addr", req_addr, 0);
    cyc();
    hreset = 1'b0;
    cyc();
    chk("rst_after_valid", req_valid, 0);
    chk("rst_after_hready", hready_out, 1);

    // posted write followed by a read of the same address
    req_ready = 1'b1;
    addr_ph(1'b1, 32'h8000_0010);
    cyc();
    hwdata = 32'hA5A5_0001;
    addr_ph(1'b0, 32'h8000_0010);
    chk("rd_wr_hready", hready_out, 1);
    cyc();
    idle();
    chk("rd_wait_1", hready_out, 0);
    chk("rd_head_w", req_write, 1);
    chk("rd_head_wdata", req_wdata, 32'hA5A5_0001);
    cyc();
    chk("rd_wait_2", hready_out, 0);
    chk("rd_head_r", req_write, 0);
    chk("rd_head_raddr", req_addr, 32'h8000_0010);
    chk("rd_head_rwdata", req_wdata, 0);
    chk("rd_head_rsel", req_sel, 3'b001);
    cyc();
    rd_valid = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    chk("rd_wait_3", hready_out, 0);
    cyc();
    rd_valid = 1'b0;
    chk("rd_done_hready", hready_out, 1);
    chk("rd_done_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("rd_done_hresp", hresp, 0);
    cyc();

    // gating: IDLE, BUSY, and NONSEQ with hready_in low
    for (int g = 0; g < 3; g++) begin
      htrans = (g == 0) ? 2'b00 : (g == 1) ? 2'b01 : 2'b10;
      hready_in = (g != 2);
      hwrite = 1'b1;
      haddr = 32'h8000_0020;
      cyc();
      htrans = 2'b00;
      hready_in = 1'b1;
      chk("gate_hready", hready_out, 1);
      chk("gate_hresp", hresp, 0);
      cyc();
      chk("gate_nopush", req_valid, 0);
    end
    rd_valid = 1'b1;
    rd_data = 32'h1234_5678;
    cyc();
    rd_valid = 1'b0;
    cyc();
    chk("stray_rd_hrdata", hrdata, 32'hDEAD_BEEF);

    // randomized traffic against the ordered-request scoreboard
    for (int c = 0; c < 2600; c++) begin
      drain = (c >= 2000);
      if (drain && !cur_v && exp_q.size() == 0 &&
          !req_valid && rd_cd == 0) break;
      rd_valid = 1'b0;
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          rd_valid = 1'b1;
          rd_data = rd_val;
        end
      end
      chk("rnd_hresp", hresp,
          (cur_v && !cur_map) ? 2'b01 : 2'b00);
      if (!cur_v) chk("rnd_hready_idle", hready_out, 1);
      hwdata = (cur_v && cur_w) ? cur_wd : $urandom;
      if (hready_out) begin
        if (cur_v && cur_map && !cur_w)
          chk("rnd_hrdata", hrdata, rexp);
        cur_v = 0;
        stall = 0;
        htrans = drain ? 2'b00 : 2'($urandom_range(0, 3));
        hready_in = ($urandom_range(0, 7) != 0);
        hwrite = 1'($urandom_range(0, 1));
        haddr = pick_addr();
        if (hready_in && htrans[1]) begin
          cur_v = 1;
          cur_w = hwrite;
          cur_map = (region(haddr) != 3'b000);
          cur_wd = $urandom;
          if (cur_map) begin
            e.w = hwrite;
            e.a = haddr;
            e.d = hwrite ? cur_wd : 32'h0;
            e.s = region(haddr);
            exp_q.push_back(e);
          end
        end
      end else begin
        htrans = 2'b00;
        stall++;
        if (stall > 60) begin
          abort = 1;
          break;
        end
      end
      req_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready) begin
        chk("rnd_q_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rnd_req_write", req_write, e.w);
          chk("rnd_req_addr", req_addr, e.a);
          chk("rnd_req_wdata", req_wdata, e.d);
          chk("rnd_req_sel", req_sel, e.s);
          if (!e.w) begin
            rd_val = $urandom;
            rexp = rd_val;
            rd_cd = int'($urandom_range(1, 3));
          end
        end
      end
      cyc();
    end
    chk("rnd_no_hang", 64'(abort), 0);
    chk("rnd_model_empty", 64'(exp_q.size()), 0);
    chk("rnd_fifo_empty", req_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_slave_fifo.md
# ahb_slave_fifo

Parametrised AHB slave front-end for the AHB-to-APB bridge. It decodes the address into N one-hot slave selects and flags unmapped transfers with a two-cycle AHB ERROR response. Mapped reads and writes go into a DEPTH-entry request FIFO, consumed by the APB-side controller through a valid/ready handshake. Unlike the fixed 3-select, 2-stage pipeline it replaces, it inserts wait states (hready_out) when the FIFO is full or a read is outstanding, and returns read data (hrdata).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SEL, 3, number of slave regions (1..8)
- BASE_ADDR, 32'h8000_0000, start of region 0
- REGION_SHIFT, 26, log2 of region size (64 MB default)
- DEPTH, 4, request FIFO entries (power of 2, >=2)

Ports:
- hclk  in  1  clock, rising edge
- hreset  in  1  asynchronous, active-high reset
- hwrite  in  1  transfer direction, 1 = write
- hready_in  in  1  bus ready
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- haddr  in  ADDR_W  address
- hwdata  in  DATA_W  write data (data phase)
- hready_out  out  1  slave ready / wait-state control
- hresp  out  2  00 OKAY, 01 ERROR
- hrdata  out  DATA_W  read data
- req_valid  out  1  FIFO head valid
- req_ready  in  1  consumer accepts head
- req_write  out  1  head direction
- req_addr  out  ADDR_W  head address
- req_wdata  out  DATA_W  head write data (0 for reads)
- req_sel  out  NUM_SEL  head one-hot select
- rd_valid  in  1  read data returned
- rd_data  in  DATA_W  returned read data

## Operation
- Accept: acc = hready_in & htrans[1] & hready_out. IDLE and BUSY transfers are never accepted; they get OKAY with zero wait.
- On acc, register hwrite, haddr, sel and map_ok.
  - map_ok = (haddr >= BASE_ADDR) & (haddr < BASE_ADDR + (NUM_SEL << REGION_SHIFT)).
  - sel = 1 << ((haddr - BASE_ADDR) >> REGION_SHIFT) when map_ok, else 0.
- Data-phase state machine:
  - IDLE: no data phase pending.
  - WDATA: write data phase. Push {1, addr, hwdata, sel} when FIFO not full; hold the state while full.
  - RREQ: read data phase. Push {0, addr, 0, sel} when not full, then go to RWAIT.
  - RWAIT: on rd_valid, hrdata <= rd_data, go to RDONE.
  - RDONE: read completes, OKAY.
  - ERR1 -> ERR2: ERROR response, no FIFO push.
- From any state with hready_out=1 (IDLE, WDATA not full, RDONE, ERR2), the next state comes from acc:
  - mapped write -> WDATA
  - mapped read -> RREQ
  - unmapped -> ERR1
  - no acc -> IDLE
- hready_out is decoded from state and FIFO full:
  - 1 in IDLE, RDONE, ERR2, and WDATA when not full.
  - 0 in WDATA when full, RREQ, RWAIT and ERR1.
- hresp = 01 in ERR1 and ERR2, else 00.
- FIFO ordering and pointers:
  - Reads queue behind posted writes, so requests are strictly ordered.
  - Push is qualified by !full only: no pass-through when full, even if a pop happens in the same cycle.
  - Pop on req_valid & req_ready.
  - A simultaneous push and pop when not full leaves the count unchanged. Pointers wrap modulo DEPTH.
- rd_valid outside RWAIT is ignored. hrdata holds its last value until the next read capture.

## Timing
- Reset (asynchronous, takes effect immediately, also mid-transfer):
  - Outputs: hready_out=1, hresp=00, hrdata=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_sel=0.
  - Internal: FIFO emptied, pending transfer discarded, state IDLE.
- Write with FIFO not full: address phase in cycle N, data phase in N+1 with hready_out=1. The entry appears on req_valid in N+2.
- Write with FIFO full: hready_out=0 from N+1 until the cycle after a pop frees an entry. hwdata is sampled in the cycle hready_out=1.
- Read, minimum latency:
  - N: address phase.
  - N+1: push, hready_out=0.
  - N+2: req_valid; pops if req_ready=1.
  - N+3: earliest rd_valid.
  - N+4: hready_out=1, hrdata valid.
- Unmapped transfer: address phase in N; N+1 has hready_out=0, hresp=01; N+2 has hready_out=1, hresp=01. A new transfer may be accepted in N+2.
- Back-to-back writes with the FIFO draining (req_ready=1) sustain one transfer per cycle.

## Test plan
- Reset: hreset=1 mid-write-stall -> hready_out=1, hresp=00, req_valid=0 in the same cycle, FIFO empty after release.
- Decode: NONSEQ writes to 0x8140_1C85, 0x8440_1C85 and 0x8840_1C85 -> req_sel = 001, 010, 100; req_wdata equals the hwdata given; zero wait states.
- Unmapped: write to 0x8C40_1C85 (NUM_SEL=3) -> hresp=01 for 2 cycles, hready_out 0 then 1, no FIFO push.
- Backpressure: req_ready=0 with 5 back-to-back writes (DEPTH=4) -> 4 accepted with zero wait, 5th holds hready_out=0. Raise req_ready -> the 5th completes the cycle after the first pop, and order is preserved.
- Read: write 0xA5A5_0001 to 0x8000_0010, then read 0x8000_0010 with the consumer returning rd_data=0xDEAD_BEEF 1 cycle after pop -> the write pops first, hrdata=0xDEAD_BEEF with hready_out=1 four cycles after the read address phase.
- Gating: htrans=00/01, or hready_in=0 with htrans=10 -> no push, hready_out=1, hresp=00; a stray rd_valid in IDLE leaves hrdata unchanged.
